// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared constants and scanner state encoding for vec_data_mem (build option: VEC_MEM_FWD_EN)
package vec_mem_pkg;

  // Default geometry of the memory and the framebuffer window
  localparam int VM_LANES    = 4;
  localparam int VM_LANE_W   = 8;
  localparam int VM_DEPTH    = 1024;
  localparam int VM_FB_BASE  = 512;
  localparam int VM_FB_WORDS = 16;

  // Scanner state encoding (IDLE, FETCH, STREAM)
  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_IDLE   = 2'd0;
  localparam scan_state_t ST_FETCH  = 2'd1;
  localparam scan_state_t ST_STREAM = 2'd2;

endpackage

// File: rtl/vec_mem_scanner.sv
// rtl/vec_mem_scanner.sv - framebuffer scanner FSM streaming one lane per pixel
module vec_mem_scanner
  import vec_mem_pkg::*;
#(
  parameter int LANES    = VM_LANES,
  parameter int LANE_W   = VM_LANE_W,
  parameter int AW       = 10,
  parameter int FB_BASE  = VM_FB_BASE,
  parameter int FB_WORDS = VM_FB_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vga_start,
  input  logic                      vga_ready,
  input  logic [LANES*LANE_W-1:0]   fetch_data,
  output logic [AW-1:0]             fetch_addr,
  output logic                      vga_valid,
  output logic [LANE_W-1:0]         out_data_vga,
  output logic                      vga_last,
  output logic                      vga_busy
);

  localparam int W  = LANES * LANE_W;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(FB_WORDS + 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  scan_state_t     state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   words_left_q, words_left_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [W-1:0]    pix_q, pix_d;

  // Outputs come straight from registers so reset clears them without a clock
  assign fetch_addr   = ptr_q;
  assign vga_valid    = (state_q == ST_STREAM);
  assign vga_busy     = (state_q != ST_IDLE);
  assign vga_last     = (state_q == ST_STREAM) && (lane_q == LANE_LAST) && (words_left_q == '0);
  assign out_data_vga = pix_q[lane_q*LANE_W +: LANE_W];

  // Next-state logic: start, one-cycle fetch, then lane-by-lane streaming with backpressure
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    words_left_d = words_left_q;
    lane_d       = lane_q;
    pix_d        = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (vga_start) begin
          state_d      = ST_FETCH;
          ptr_d        = AW'(FB_BASE);
          words_left_d = CW'(FB_WORDS - 1);
          lane_d       = '0;
        end
      end
      ST_FETCH: begin
        pix_d   = fetch_data;
        lane_d  = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (vga_ready) begin
          if (lane_q != LANE_LAST) begin
            lane_d = lane_q + 1'b1;
          end else if (words_left_q != '0) begin
            ptr_d        = ptr_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            state_d      = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scanner registers; reset aborts any frame in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      words_left_q <= '0;
      lane_q       <= '0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      words_left_q <= words_left_d;
      lane_q       <= lane_d;
      pix_q        <= pix_d;
    end
  end

endmodule

// File: rtl/vec_data_mem.sv
// rtl/vec_data_mem.sv - lane-masked vector data memory with CPU port and framebuffer scanner (option: VEC_MEM_FWD_EN)
module vec_data_mem
  import vec_mem_pkg::*;
#(
  parameter int LANES    = VM_LANES,
  parameter int LANE_W   = VM_LANE_W,
  parameter int DEPTH    = VM_DEPTH,
  parameter int FB_BASE  = VM_FB_BASE,
  parameter int FB_WORDS = VM_FB_WORDS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              cpu_addr,
  input  logic                     wr_enable,
  input  logic [LANES-1:0]         lane_mask,
  input  logic [LANES*LANE_W-1:0]  cpu_data,
  output logic [LANES*LANE_W-1:0]  mem_data,
  input  logic                     vga_start,
  input  logic                     vga_ready,
  output logic                     vga_valid,
  output logic [LANE_W-1:0]        out_data_vga,
  output logic                     vga_last,
  output logic                     vga_busy
);

  localparam int W  = LANES * LANE_W;
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic          addr_ok;
  logic          wr_ok;
  logic [AW-1:0] cpu_idx;
  logic [AW-1:0] scan_addr;
  logic [W-1:0]  cpu_rd_word;
  logic [W-1:0]  scan_rd_word;
  logic [W-1:0]  mem_data_d, mem_data_q;

  assign addr_ok  = (cpu_addr < 32'(DEPTH));
  assign cpu_idx  = cpu_addr[AW-1:0];
  assign wr_ok    = wr_enable && addr_ok;
  assign mem_data = mem_data_q;

  // Storage write: only enabled lanes of an in-range word change; array is never reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i]) begin
          mem[cpu_idx][i*LANE_W +: LANE_W] <= cpu_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Two independent read ports; with forwarding, a same-cycle write shows through on its masked lanes
  always_comb begin
    cpu_rd_word  = mem[cpu_idx];
    scan_rd_word = mem[scan_addr];
`ifdef VEC_MEM_FWD_EN
    for (int i = 0; i < LANES; i++) begin
      if (wr_ok && lane_mask[i]) begin
        cpu_rd_word[i*LANE_W +: LANE_W] = cpu_data[i*LANE_W +: LANE_W];
        if (scan_addr == cpu_idx) begin
          scan_rd_word[i*LANE_W +: LANE_W] = cpu_data[i*LANE_W +: LANE_W];
        end
      end
    end
`endif
    mem_data_d = addr_ok ? cpu_rd_word : '0;
  end

  // Registered CPU read data, updated every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_q <= '0;
    end else begin
      mem_data_q <= mem_data_d;
    end
  end

  vec_mem_scanner #(
    .LANES    (LANES),
    .LANE_W   (LANE_W),
    .AW       (AW),
    .FB_BASE  (FB_BASE),
    .FB_WORDS (FB_WORDS)
  ) u_scanner (
    .clk          (clk),
    .reset        (reset),
    .vga_start    (vga_start),
    .vga_ready    (vga_ready),
    .fetch_data   (scan_rd_word),
    .fetch_addr   (scan_addr),
    .vga_valid    (vga_valid),
    .out_data_vga (out_data_vga),
    .vga_last     (vga_last),
    .vga_busy     (vga_busy)
  );

endmodule

// File: tb/tb_vec_data_mem.sv
// tb/tb_vec_data_mem.sv - self-checking bench for vec_data_mem (expectations follow VEC_MEM_FWD_EN)
module tb_vec_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        wr_enable;
  logic [3:0]  lane_mask;
  logic [31:0] cpu_data;
  logic [31:0] mem_data;
  logic        vga_start;
  logic        vga_ready;
  logic        vga_valid;
  logic [7:0]  out_data_vga;
  logic        vga_last;
  logic        vga_busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } cpu_vec_t;

  cpu_vec_t    vecs[$];
  logic [31:0] cpu_exp_q[$];
  logic [7:0]  pix_exp_q[$];
  logic        last_exp_q[$];

  vec_data_mem #(
    .LANES(4), .LANE_W(8), .DEPTH(1024), .FB_BASE(512), .FB_WORDS(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .wr_enable    (wr_enable),
    .lane_mask    (lane_mask),
    .cpu_data     (cpu_data),
    .mem_data     (mem_data),
    .vga_start    (vga_start),
    .vga_ready    (vga_ready),
    .vga_valid    (vga_valid),
    .out_data_vga (out_data_vga),
    .vga_last     (vga_last),
    .vga_busy     (vga_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] w0, input logic [31:0] w1,
                           input int stall_at, input int stall_n, input bit mid_start,
                           input bit wr_fetch, input logic [31:0] wr_data, input logic [3:0] wr_mask);
    logic [31:0] words [2];
    int got = 0;
    int stalled = 0;
    int bubbles = 0;
    int bubble_at = -1;
    int cyc = 0;
    words[0] = w0;
    words[1] = w1;
    pix_exp_q.delete();
    last_exp_q.delete();
    for (int w = 0; w < 2; w++) begin
      for (int l = 0; l < 4; l++) begin
        pix_exp_q.push_back(words[w][l*8 +: 8]);
        last_exp_q.push_back((w == 1) && (l == 3));
      end
    end
    vga_ready = 1'b1;
    vga_start = 1'b1;
    tick();
    vga_start = 1'b0;
    check("fetch_busy", 32'(vga_busy), 32'd1);
    check("fetch_valid", 32'(vga_valid), 32'd0);
    if (wr_fetch) begin
      cpu_addr  = 32'd512;
      wr_enable = 1'b1;
      lane_mask = wr_mask;
      cpu_data  = wr_data;
    end
    while (pix_exp_q.size() > 0 && cyc < 100) begin
      vga_ready = !((got == stall_at) && (stalled < stall_n));
      vga_start = mid_start && (got == 3);
      if (vga_valid) begin
        check("pix_data", 32'(out_data_vga), 32'(pix_exp_q[0]));
        check("pix_last", 32'(vga_last), 32'(last_exp_q[0]));
        if (vga_ready) begin
          void'(pix_exp_q.pop_front());
          void'(last_exp_q.pop_front());
          got++;
        end else begin
          stalled++;
        end
      end else if (got > 0) begin
        bubbles++;
        bubble_at = got;
      end
      tick();
      cyc++;
      wr_enable = 1'b0;
      cpu_addr  = 32'd0;
    end
    vga_start = 1'b0;
    vga_ready = 1'b1;
    check("frame_left", 32'(pix_exp_q.size()), 32'd0);
    check("bubble_count", 32'(bubbles), 32'd1);
    check("bubble_pos", 32'(bubble_at), 32'd4);
    check("end_busy", 32'(vga_busy), 32'd0);
    check("end_valid", 32'(vga_valid), 32'd0);
    check("stall_cycles", 32'(stalled), 32'(stall_n));
  endtask

  logic [31:0] fwd_cpu_exp;
  logic [31:0] fwd_pix_w0;

  initial begin
`ifdef VEC_MEM_FWD_EN
    fwd_cpu_exp = 32'h0102BBBB;
    fwd_pix_w0  = 32'h0403C0D0;
`else
    fwd_cpu_exp = 32'h01020304;
    fwd_pix_w0  = 32'h04030201;
`endif
    reset     = 1'b1;
    cpu_addr  = '0;
    wr_enable = 1'b0;
    lane_mask = '0;
    cpu_data  = '0;
    vga_start = 1'b0;
    vga_ready = 1'b1;
    #3;
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_valid", 32'(vga_valid), 32'd0);
    check("rst_busy", 32'(vga_busy), 32'd0);
    check("rst_last", 32'(vga_last), 32'd0);
    check("rst_pixel", 32'(out_data_vga), 32'd0);
    tick();
    reset = 1'b0;

    // CPU port vectors: {addr, we, mask, data, check, expected mem_data after the edge}
    vecs.push_back('{32'd5,    1'b1, 4'hF, 32'hAABBCCDD, 1'b0, 32'h0});
    vecs.push_back('{32'd5,    1'b0, 4'h0, 32'h0,        1'b1, 32'hAABBCCDD});
    vecs.push_back('{32'd5,    1'b1, 4'h5, 32'h11223344, 1'b0, 32'h0});
    vecs.push_back('{32'd5,    1'b0, 4'h0, 32'h0,        1'b1, 32'hAA22CC44});
    vecs.push_back('{32'd976,  1'b1, 4'hF, 32'h00000000, 1'b0, 32'h0});
    vecs.push_back('{32'd2000, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0});
    vecs.push_back('{32'd2000, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{32'd976,  1'b0, 4'h0, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{32'd1023, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{32'd1024, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h0});
    vecs.push_back('{32'd1023, 1'b0, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D});
    vecs.push_back('{32'd5,    1'b1, 4'h8, 32'h99000000, 1'b0, 32'h0});
    vecs.push_back('{32'd5,    1'b0, 4'h0, 32'h0,        1'b1, 32'h9922CC44});
    vecs.push_back('{32'd7,    1'b1, 4'hF, 32'h01020304, 1'b0, 32'h0});
    vecs.push_back('{32'd7,    1'b1, 4'h3, 32'hAAAABBBB, 1'b1, fwd_cpu_exp});
    vecs.push_back('{32'd7,    1'b0, 4'h0, 32'h0,        1'b1, 32'h0102BBBB});
    vecs.push_back('{32'd512,  1'b1, 4'hF, 32'h04030201, 1'b0, 32'h0});
    vecs.push_back('{32'd513,  1'b1, 4'hF, 32'h08070605, 1'b0, 32'h0});
    vecs.push_back('{32'd512,  1'b0, 4'h0, 32'h0,        1'b1, 32'h04030201});

    for (int i = 0; i < vecs.size(); i++) begin
      cpu_addr  = vecs[i].addr;
      wr_enable = vecs[i].we;
      lane_mask = vecs[i].mask;
      cpu_data  = vecs[i].data;
      if (vecs[i].chk) cpu_exp_q.push_back(vecs[i].exp);
      tick();
      if (vecs[i].chk) check($sformatf("cpu_vec%0d", i), mem_data, cpu_exp_q.pop_front());
    end
    wr_enable = 1'b0;
    cpu_addr  = 32'd0;

    // Plain frame, then stalled frame with an ignored mid-frame start
    run_frame(32'h04030201, 32'h08070605, -1, 0, 1'b0, 1'b0, 32'h0, 4'h0);
    run_frame(32'h04030201, 32'h08070605, 1, 3, 1'b1, 1'b0, 32'h0, 4'h0);

    // Reset during STREAM takes effect without a clock edge
    vga_ready = 1'b1;
    vga_start = 1'b1;
    tick();
    vga_start = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", 32'(vga_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(vga_valid), 32'd0);
    check("async_rst_busy", 32'(vga_busy), 32'd0);
    check("async_rst_last", 32'(vga_last), 32'd0);
    check("async_rst_pixel", 32'(out_data_vga), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(vga_valid), 32'd0);
    run_frame(32'h04030201, 32'h08070605, -1, 0, 1'b0, 1'b0, 32'h0, 4'h0);

    // CPU write to word 512 coincident with the scanner fetching it
    run_frame(fwd_pix_w0, 32'h08070605, -1, 0, 1'b0, 1'b1, 32'hA0B0C0D0, 4'h3);
    cpu_addr = 32'd512;
    tick();
    check("post_fetch_word", mem_data, 32'h0403C0D0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
